// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
//   arb_state_t  - arbiter FSM states
//   mem_req_t    - address/data/strobe bundle latched at transaction launch
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } mem_req_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between core instruction fetch and data
// access. The fetched instruction is held in a one-entry buffer tagged with
// its address, so the core sees a stable instruction while its load/store is
// in flight. Each load/store is issued once per buffered instruction.
//
// Ports
//   clock, reset                      system clock, synchronous active-high reset
//   if_addr / if_data / if_valid      core pc in, buffered instruction out
//   d_addr, d_read_enable             load request (level, held until d_read_valid)
//   d_read_data / d_read_valid        load data, 1-cycle valid pulse
//   d_write_enable, d_write_data,
//   d_strb / d_write_ready            store request (level) and 1-cycle accept pulse
//   m_addr, m_read_enable,
//   m_write_enable, m_write_data,
//   m_strb                            registered memory request
//   m_read_data, m_read_valid,
//   m_write_ready                     memory response
//   bus_err                           1-cycle pulse when a transaction times out
//
// TIMEOUT_CYCLES: max cycles a transaction may stay open; 0 disables timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  input  logic [31:0] d_addr,
  input  logic        d_read_enable,
  output logic [31:0] d_read_data,
  output logic        d_read_valid,
  input  logic        d_write_enable,
  input  logic [31:0] d_write_data,
  input  logic [3:0]  d_strb,
  output logic        d_write_ready,
  output logic [31:0] m_addr,
  output logic        m_read_enable,
  input  logic [31:0] m_read_data,
  input  logic        m_read_valid,
  output logic        m_write_enable,
  output logic [31:0] m_write_data,
  output logic [3:0]  m_strb,
  input  logic        m_write_ready,
  output logic        bus_err
);

  arb_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] ibuf_q, ibuf_d;
  logic [31:0] ibuf_addr_q, ibuf_addr_d;
  logic        ibuf_valid_q, ibuf_valid_d;
  logic        d_done_q, d_done_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        hit;
  logic        retire;
  logic        data_pending;
  logic        timeout_hit;

  always_comb begin
    // Buffered instruction is valid only for the pc it was fetched for.
    hit          = ibuf_valid_q && (ibuf_addr_q == if_addr);
    // Core moved to a new pc: drop the stale instruction and its data flag.
    retire       = ibuf_valid_q && (ibuf_addr_q != if_addr);
    data_pending = hit && !d_done_q && (d_read_enable || d_write_enable);
    // Fires in the last allowed open cycle so the enables drop after exactly
    // TIMEOUT_CYCLES cycles on the bus.
    timeout_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TIMEOUT_CYCLES - 1);
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    req_d        = req_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    ibuf_d       = ibuf_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_valid_d = ibuf_valid_q;
    d_done_d     = d_done_q;
    tmo_cnt_d    = tmo_cnt_q + 32'd1;
    bus_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (retire) begin
          ibuf_valid_d = 1'b0;
          d_done_d     = 1'b0;
        end else if (data_pending) begin
          req_d.addr = d_addr;
          if (d_read_enable) begin
            state_d = DREAD;
            rd_en_d = 1'b1;
          end else begin
            state_d     = DWRITE;
            wr_en_d     = 1'b1;
            req_d.wdata = d_write_data;
            req_d.strb  = d_strb;
          end
        end else if (!hit) begin
          state_d    = IFETCH;
          rd_en_d    = 1'b1;
          req_d.addr = if_addr;
        end
      end

      IFETCH: begin
        if (m_read_valid) begin
          // Buffered even if the pc has moved on; the address tag then
          // mismatches and the entry is retired on the next IDLE cycle.
          ibuf_d       = m_read_data;
          ibuf_addr_d  = req_q.addr;
          ibuf_valid_d = 1'b1;
          rd_en_d      = 1'b0;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          rd_en_d   = 1'b0;
          state_d   = IDLE;
        end
      end

      DREAD: begin
        if (m_read_valid || timeout_hit) begin
          // d_done also on timeout so the core is not left re-issuing forever.
          bus_err_d = !m_read_valid;
          d_done_d  = 1'b1;
          rd_en_d   = 1'b0;
          state_d   = IDLE;
        end
      end

      DWRITE: begin
        if (m_write_ready || timeout_hit) begin
          bus_err_d = !m_write_ready;
          d_done_d  = 1'b1;
          wr_en_d   = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      ibuf_q       <= '0;
      ibuf_addr_q  <= '0;
      ibuf_valid_q <= 1'b0;
      d_done_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      ibuf_q       <= ibuf_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_valid_q <= ibuf_valid_d;
      d_done_q     <= d_done_d;
      tmo_cnt_q    <= tmo_cnt_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Outputs. Responses are forwarded only while the matching transaction is
  // open, so stray or late memory handshakes never reach the core.
  always_comb begin
    if_data        = ibuf_q;
    if_valid       = hit;
    d_read_data    = m_read_data;
    d_read_valid   = (state_q == DREAD) && m_read_valid;
    d_write_ready  = (state_q == DWRITE) && m_write_ready;
    m_addr         = req_q.addr;
    m_write_data   = req_q.wdata;
    m_strb         = req_q.strb;
    m_read_enable  = rd_en_q;
    m_write_enable = wr_en_q;
    bus_err        = bus_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table for the
// fetch/load/store flow, then hand-written timeout and reset sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_valid;
  logic [31:0] d_addr;
  logic        d_read_enable;
  logic [31:0] d_read_data;
  logic        d_read_valid;
  logic        d_write_enable;
  logic [31:0] d_write_data;
  logic [3:0]  d_strb;
  logic        d_write_ready;
  logic [31:0] m_addr;
  logic        m_read_enable;
  logic [31:0] m_read_data;
  logic        m_read_valid;
  logic        m_write_enable;
  logic [31:0] m_write_data;
  logic [3:0]  m_strb;
  logic        m_write_ready;
  logic        bus_err;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .d_addr(d_addr), .d_read_enable(d_read_enable),
    .d_read_data(d_read_data), .d_read_valid(d_read_valid),
    .d_write_enable(d_write_enable), .d_write_data(d_write_data),
    .d_strb(d_strb), .d_write_ready(d_write_ready),
    .m_addr(m_addr), .m_read_enable(m_read_enable),
    .m_read_data(m_read_data), .m_read_valid(m_read_valid),
    .m_write_enable(m_write_enable), .m_write_data(m_write_data),
    .m_strb(m_strb), .m_write_ready(m_write_ready),
    .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        reset;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic        d_re;
    logic        d_we;
    logic [31:0] d_wdata;
    logic [3:0]  d_strb;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_wready;
  } in_t;

  typedef struct packed {
    logic        if_valid;
    logic [31:0] if_data;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_wready;
    logic [31:0] m_addr;
    logic        m_re;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_strb;
    logic        bus_err;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam int NVEC = 30;
  vec_t vecs [NVEC];

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic in_t mk_in(int rst, logic [31:0] pc, logic [31:0] da, int re, int we,
                                logic [31:0] wd, logic [3:0] st, logic [31:0] rd, int rv, int wr);
    in_t r;
    r.reset = (rst != 0); r.if_addr = pc; r.d_addr = da;
    r.d_re = (re != 0); r.d_we = (we != 0); r.d_wdata = wd; r.d_strb = st;
    r.m_rdata = rd; r.m_rvalid = (rv != 0); r.m_wready = (wr != 0);
    return r;
  endfunction

  function automatic out_t mk_out(int iv, logic [31:0] id, int drv, logic [31:0] drd, int dwr,
                                  logic [31:0] ma, int mre, int mwe, logic [31:0] mwd,
                                  logic [3:0] mst, int be);
    out_t r;
    r.if_valid = (iv != 0); r.if_data = id; r.d_rvalid = (drv != 0); r.d_rdata = drd;
    r.d_wready = (dwr != 0); r.m_addr = ma; r.m_re = (mre != 0); r.m_we = (mwe != 0);
    r.m_wdata = mwd; r.m_strb = mst; r.bus_err = (be != 0);
    return r;
  endfunction

  task automatic drive(input in_t v);
    reset          = v.reset;
    if_addr        = v.if_addr;
    d_addr         = v.d_addr;
    d_read_enable  = v.d_re;
    d_write_enable = v.d_we;
    d_write_data   = v.d_wdata;
    d_strb         = v.d_strb;
    m_read_data    = v.m_rdata;
    m_read_valid   = v.m_rvalid;
    m_write_ready  = v.m_wready;
  endtask

  function automatic out_t sample();
    out_t r;
    r.if_valid = if_valid; r.if_data = if_data; r.d_rvalid = d_read_valid;
    r.d_rdata = d_read_data; r.d_wready = d_write_ready; r.m_addr = m_addr;
    r.m_re = m_read_enable; r.m_we = m_write_enable; r.m_wdata = m_write_data;
    r.m_strb = m_strb; r.bus_err = bus_err;
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Each row: inputs held for one cycle, outputs expected during that cycle.
    // in : rst, pc, d_addr, re, we, d_wdata, d_strb, m_rdata, m_rvalid, m_wready
    // out: if_valid, if_data, d_rvalid, d_rdata, d_wready, m_addr, m_re, m_we, m_wdata, m_strb, bus_err
    // reset state, then fetch 0x8000_0000 answered in the 2nd open cycle
    vecs[0]  = '{mk_in(1, 32'h8000_0000, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, '0, 0, '0, 0, '0, 0, 0, '0, '0, 0)};
    vecs[1]  = '{mk_in(0, 32'h8000_0000, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, '0, 0, '0, 0, '0, 0, 0, '0, '0, 0)};
    vecs[2]  = '{mk_in(0, 32'h8000_0000, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, '0, 0, '0, 0, 32'h8000_0000, 1, 0, '0, '0, 0)};
    vecs[3]  = '{mk_in(0, 32'h8000_0000, '0, 0, 0, '0, '0, 32'h13, 1, 0), mk_out(0, '0, 0, 32'h13, 0, 32'h8000_0000, 1, 0, '0, '0, 0)};
    // lw 0x8000_1000, zero-wait answer, no re-issue, stray m_read_valid ignored
    vecs[4]  = '{mk_in(0, 32'h8000_0000, 32'h8000_1000, 1, 0, '0, '0, '0, 0, 0), mk_out(1, 32'h13, 0, '0, 0, 32'h8000_0000, 0, 0, '0, '0, 0)};
    vecs[5]  = '{mk_in(0, 32'h8000_0000, 32'h8000_1000, 1, 0, '0, '0, 32'hDEAD_BEEF, 1, 0), mk_out(1, 32'h13, 1, 32'hDEAD_BEEF, 0, 32'h8000_1000, 1, 0, '0, '0, 0)};
    vecs[6]  = '{mk_in(0, 32'h8000_0000, 32'h8000_1000, 1, 0, '0, '0, '0, 0, 0), mk_out(1, 32'h13, 0, '0, 0, 32'h8000_1000, 0, 0, '0, '0, 0)};
    vecs[7]  = '{mk_in(0, 32'h8000_0000, 32'h8000_1000, 1, 0, '0, '0, 32'hBAD, 1, 0), mk_out(1, 32'h13, 0, 32'hBAD, 0, 32'h8000_1000, 0, 0, '0, '0, 0)};
    // pc -> 0x8000_0004: retire cycle, then fetch
    vecs[8]  = '{mk_in(0, 32'h8000_0004, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'h13, 0, '0, 0, 32'h8000_1000, 0, 0, '0, '0, 0)};
    vecs[9]  = '{mk_in(0, 32'h8000_0004, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'h13, 0, '0, 0, 32'h8000_1000, 0, 0, '0, '0, 0)};
    vecs[10] = '{mk_in(0, 32'h8000_0004, '0, 0, 0, '0, '0, 32'h0011_2423, 1, 0), mk_out(0, 32'h13, 0, 32'h0011_2423, 0, 32'h8000_0004, 1, 0, '0, '0, 0)};
    // sw, core changes data/strb after launch, ready on the 3rd open cycle
    vecs[11] = '{mk_in(0, 32'h8000_0004, 32'h8000_2000, 0, 1, 32'h1234_5678, 4'h3, '0, 0, 0), mk_out(1, 32'h0011_2423, 0, '0, 0, 32'h8000_0004, 0, 0, '0, '0, 0)};
    vecs[12] = '{mk_in(0, 32'h8000_0004, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 0), mk_out(1, 32'h0011_2423, 0, '0, 0, 32'h8000_2000, 0, 1, 32'h1234_5678, 4'h3, 0)};
    vecs[13] = '{mk_in(0, 32'h8000_0004, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 0), mk_out(1, 32'h0011_2423, 0, '0, 0, 32'h8000_2000, 0, 1, 32'h1234_5678, 4'h3, 0)};
    vecs[14] = '{mk_in(0, 32'h8000_0004, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 1), mk_out(1, 32'h0011_2423, 0, '0, 1, 32'h8000_2000, 0, 1, 32'h1234_5678, 4'h3, 0)};
    vecs[15] = '{mk_in(0, 32'h8000_0004, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 0), mk_out(1, 32'h0011_2423, 0, '0, 0, 32'h8000_2000, 0, 0, 32'h1234_5678, 4'h3, 0)};
    // pc change with old store still held: store suppressed, fetch issued
    vecs[16] = '{mk_in(0, 32'h8000_0008, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 1), mk_out(0, 32'h0011_2423, 0, '0, 0, 32'h8000_2000, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[17] = '{mk_in(0, 32'h8000_0008, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, '0, 0, 0), mk_out(0, 32'h0011_2423, 0, '0, 0, 32'h8000_2000, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[18] = '{mk_in(0, 32'h8000_0008, 32'h8000_2000, 0, 1, 32'hFFFF_FFFF, 4'hF, 32'h13, 1, 0), mk_out(0, 32'h0011_2423, 0, 32'h13, 0, 32'h8000_0008, 1, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[19] = '{mk_in(0, 32'h8000_0008, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(1, 32'h13, 0, '0, 0, 32'h8000_0008, 0, 0, 32'h1234_5678, 4'h3, 0)};
    // pc changes during an open fetch: result buffered, then retired
    vecs[20] = '{mk_in(0, 32'h8000_000C, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'h13, 0, '0, 0, 32'h8000_0008, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[21] = '{mk_in(0, 32'h8000_000C, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'h13, 0, '0, 0, 32'h8000_0008, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[22] = '{mk_in(0, 32'h8000_0100, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'h13, 0, '0, 0, 32'h8000_000C, 1, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[23] = '{mk_in(0, 32'h8000_0100, '0, 0, 0, '0, '0, 32'hAAAA_0001, 1, 0), mk_out(0, 32'h13, 0, 32'hAAAA_0001, 0, 32'h8000_000C, 1, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[24] = '{mk_in(0, 32'h8000_0100, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'hAAAA_0001, 0, '0, 0, 32'h8000_000C, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[25] = '{mk_in(0, 32'h8000_0100, '0, 0, 0, '0, '0, '0, 0, 0), mk_out(0, 32'hAAAA_0001, 0, '0, 0, 32'h8000_000C, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[26] = '{mk_in(0, 32'h8000_0100, '0, 0, 0, '0, '0, 32'h13, 1, 0), mk_out(0, 32'hAAAA_0001, 0, 32'h13, 0, 32'h8000_0100, 1, 0, 32'h1234_5678, 4'h3, 0)};
    // read and write both requested: read wins, write never issued
    vecs[27] = '{mk_in(0, 32'h8000_0100, 32'h8000_3000, 1, 1, 32'h55, 4'hF, '0, 0, 0), mk_out(1, 32'h13, 0, '0, 0, 32'h8000_0100, 0, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[28] = '{mk_in(0, 32'h8000_0100, 32'h8000_3000, 1, 1, 32'h55, 4'hF, 32'h77, 1, 0), mk_out(1, 32'h13, 1, 32'h77, 0, 32'h8000_3000, 1, 0, 32'h1234_5678, 4'h3, 0)};
    vecs[29] = '{mk_in(0, 32'h8000_0100, 32'h8000_3000, 1, 1, 32'h55, 4'hF, '0, 0, 0), mk_out(1, 32'h13, 0, '0, 0, 32'h8000_3000, 0, 0, 32'h1234_5678, 4'h3, 0)};

    drive(mk_in(1, '0, '0, 0, 0, '0, '0, '0, 0, 0));
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].in);
      @(negedge clock);
      check($sformatf("vec%0d", i), 160'(sample()), 160'(vecs[i].exp));
      step();
    end

    // Fetch timeout: memory silent for 4 open cycles.
    drive(mk_in(0, 32'h8000_0200, '0, 0, 0, '0, '0, '0, 0, 0));
    step();  // retire
    step();  // launch
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("ifetch_open%0d_re", k), 160'(m_read_enable), 160'(1'b1));
      check($sformatf("ifetch_open%0d_err", k), 160'(bus_err), 160'(1'b0));
      step();
    end
    @(negedge clock);
    check("ifetch_tmo_err", 160'(bus_err), 160'(1'b1));
    check("ifetch_tmo_re", 160'(m_read_enable), 160'(1'b0));
    check("ifetch_tmo_state", 160'(dut.state_q), 160'(IDLE));
    step();
    drive(mk_in(0, 32'h8000_0200, '0, 0, 0, '0, '0, 32'h13, 1, 0));
    @(negedge clock);
    check("refetch_err_clear", 160'(bus_err), 160'(1'b0));
    check("refetch_re", 160'(m_read_enable), 160'(1'b1));
    step();

    // Data read timeout: d_done set, no re-issue while the load is held.
    drive(mk_in(0, 32'h8000_0200, 32'h8000_4000, 1, 0, '0, '0, '0, 0, 0));
    @(negedge clock);
    check("dtmo_if_valid", 160'(if_valid), 160'(1'b1));
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check($sformatf("dread_open%0d", k), 160'({m_read_enable, bus_err, m_addr}),
            160'({1'b1, 1'b0, 32'h8000_4000}));
      step();
    end
    @(negedge clock);
    check("dread_tmo_err", 160'(bus_err), 160'(1'b1));
    check("dread_tmo_re", 160'(m_read_enable), 160'(1'b0));
    check("dread_tmo_rvalid", 160'(d_read_valid), 160'(1'b0));
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check($sformatf("dread_no_reissue%0d", k), 160'({m_read_enable, bus_err}), 160'(2'b00));
      step();
    end

    // Reset during an open store.
    drive(mk_in(0, 32'h8000_0204, '0, 0, 0, '0, '0, '0, 0, 0));
    step();  // retire
    step();  // launch
    drive(mk_in(0, 32'h8000_0204, '0, 0, 0, '0, '0, 32'h0011_2423, 1, 0));
    @(negedge clock);
    check("rst_seq_fetch", 160'({m_read_enable, m_addr}), 160'({1'b1, 32'h8000_0204}));
    step();
    drive(mk_in(0, 32'h8000_0204, 32'h8000_5000, 0, 1, 32'hCAFE_F00D, 4'hF, '0, 0, 0));
    @(negedge clock);
    check("rst_seq_if_valid", 160'(if_valid), 160'(1'b1));
    step();
    drive(mk_in(1, 32'h8000_0204, 32'h8000_5000, 0, 1, 32'hCAFE_F00D, 4'hF, '0, 0, 0));
    @(negedge clock);
    check("rst_seq_write_open", 160'({m_write_enable, m_addr}), 160'({1'b1, 32'h8000_5000}));
    step();
    drive(mk_in(0, 32'h8000_0204, '0, 0, 0, '0, '0, '0, 0, 1));
    @(negedge clock);
    check("rst_m_outputs", 160'({m_read_enable, m_write_enable, m_addr, m_write_data, m_strb}), 160'(0));
    check("rst_state", 160'(dut.state_q), 160'(IDLE));
    check("rst_late_wready", 160'(d_write_ready), 160'(1'b0));
    check("rst_bus_err", 160'(bus_err), 160'(1'b0));
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
